// File: rtl/ft245_pkg.sv
// Shared types and constants for the FT245 synchronous FIFO bus master.
package ft245_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_OE,
      RD,
      RD_END,
      WR
   } state_e;

   typedef enum logic {
      DIR_RD,
      DIR_WR
   } dir_e;

   // Free words kept in reserve so a read burst can always be stopped in time.
   localparam int RX_MARGIN = 2;

endpackage

// File: rtl/ft245_rx_fifo.sv
// First-word-fall-through rx buffer; pointers carry one extra bit so full and
// empty are told apart by natural wrap.
module ft245_rx_fifo
   import ft245_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int RX_DEPTH = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      push,
   input  logic [DATA_W-1:0]         push_data,
   input  logic                      pop,
   output logic [DATA_W-1:0]         pop_data,
   output logic                      empty,
   output logic                      full,
   output logic [$clog2(RX_DEPTH):0] free_cnt
);
   localparam int AW = $clog2(RX_DEPTH);
   localparam int PW = AW + 1;

   logic [DATA_W-1:0] mem_q [RX_DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]     used;

   always_comb begin
      used     = wr_ptr_q - rd_ptr_q;
      empty    = (used == '0);
      full     = (used == PW'(RX_DEPTH));
      free_cnt = PW'(RX_DEPTH) - used;
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop && !empty);
      pop_data = mem_q[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/ft245_sync_master.sv
// FPGA-side master for the FT245 synchronous FIFO bus: arbitrates read and
// write bursts, buffers received words and registers the write data.
//
//   state  | meaning
//   IDLE   | bus idle, arbitrate between read and write
//   RD_OE  | chip output enable asserted, one turnaround cycle
//   RD     | rdn low, one word pushed per cycle while rxfn low
//   RD_END | rdn released, oen released on exit
//   WR     | write burst through the one-stage dout register
module ft245_sync_master
   import ft245_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int RX_DEPTH  = 8,
   parameter int BURST_MAX = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rxfn,
   input  logic              txen,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              rdn,
   output logic              wrn,
   output logic              oen,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready
);
   localparam int            FW      = $clog2(RX_DEPTH) + 1;
   localparam int            CW      = $clog2(BURST_MAX + 1);
   localparam logic [FW-1:0] MARGIN  = FW'(RX_MARGIN);
   localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX);

   state_e            state_q, state_d;
   dir_e              last_q, last_d;
   logic              rdn_q, rdn_d;
   logic              wrn_q, wrn_d;
   logic              oen_q, oen_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [CW-1:0]     rd_cnt;
   logic [FW-1:0]     free_cnt, free_after;
   logic              push, pop, fifo_empty, fifo_full;
   logic              rd_ok, wr_ok, rd_exit, wr_exit, tx_take, consumed;

   ft245_rx_fifo #(
      .DATA_W   (DATA_W),
      .RX_DEPTH (RX_DEPTH)
   ) u_rx_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (din),
      .pop       (pop),
      .pop_data  (rx_data),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .free_cnt  (free_cnt)
   );

   assign push       = !rdn_q && !rxfn;
   assign rx_valid   = !fifo_empty;
   assign pop        = rx_valid && rx_ready;
   assign free_after = free_cnt - FW'(push);
   assign rd_ok      = !rxfn && (free_cnt > MARGIN);
   assign wr_ok      = !txen && tx_valid;
   assign rd_cnt     = cnt_q + CW'(push);
   assign rd_exit    = rxfn || (free_after <= MARGIN) || (rd_cnt == CNT_MAX);
   assign consumed   = !wrn_q && !txen;
   // Leaving WR takes priority over accepting, so no word is loaded on exit.
   assign wr_exit    = wrn_q && (txen || !tx_valid || (cnt_q == CNT_MAX));
   assign tx_ready   = (state_q == WR) && !wr_exit && (wrn_q || !txen) && (cnt_q < CNT_MAX);
   assign tx_take    = tx_valid && tx_ready;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      rdn_d   = rdn_q;
      wrn_d   = wrn_q;
      oen_d   = oen_q;
      dout_d  = dout_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (rd_ok && (!wr_ok || last_q == DIR_WR)) begin
               state_d = RD_OE;
               oen_d   = 1'b0;
               cnt_d   = '0;
               last_d  = DIR_RD;
            end else if (wr_ok) begin
               state_d = WR;
               cnt_d   = '0;
               last_d  = DIR_WR;
            end
         end
         RD_OE: begin
            state_d = RD;
            rdn_d   = 1'b0;
         end
         RD: begin
            cnt_d = rd_cnt;
            if (rd_exit) begin
               rdn_d   = 1'b1;
               state_d = RD_END;
            end
         end
         RD_END: begin
            oen_d   = 1'b1;
            state_d = IDLE;
         end
         WR: begin
            if (tx_take) begin
               dout_d = tx_data;
               wrn_d  = 1'b0;
               cnt_d  = cnt_q + 1'b1;
            end else if (consumed) begin
               wrn_d = 1'b1;
            end
            if (wr_exit) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= DIR_WR;
         rdn_q   <= 1'b1;
         wrn_q   <= 1'b1;
         oen_q   <= 1'b1;
         dout_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         rdn_q   <= rdn_d;
         wrn_q   <= wrn_d;
         oen_q   <= oen_d;
         dout_q  <= dout_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rdn  = rdn_q;
   assign wrn  = wrn_q;
   assign oen  = oen_q;
   assign dout = dout_q;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full))
      else $error("rx buffer push while full");

endmodule

// File: tb/tb_ft245_sync_master.sv
// Bench for ft245_sync_master: chip-side model, tx source and rx/tx scoreboards.
module tb_ft245_sync_master;
   import ft245_pkg::*;

   localparam int DW  = 32;
   localparam int RXD = 8;
   localparam int BM  = 4;

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b1;
   logic          rxfn     = 1'b1;
   logic          txen     = 1'b1;
   logic [DW-1:0] din      = '0;
   logic [DW-1:0] tx_data  = '0;
   logic          rx_ready = 1'b0;
   logic          tx_valid = 1'b0;
   logic [DW-1:0] dout, rx_data;
   logic          rdn, wrn, oen, rx_valid, tx_ready;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] host_q[$];   // words the chip still holds for the FPGA
   logic [DW-1:0] rx_exp[$];   // words delivered to the FPGA, not yet consumed
   logic [DW-1:0] tx_src[$];   // words the user logic still has to offer
   logic [DW-1:0] tx_exp[$];   // words handed over, not yet seen by the chip

   int rx_cnt = 0, host_got = 0, cyc = 0;
   int rdy_mode = 0;           // 0 low, 1 high, 2 random
   int txen_mode = 3;          // 0 low, 1 high every 3rd cycle, 2 random, 3 high
   int rx_block_pct = 0;
   bit track_runs = 1'b0;
   int run_len = 0, run_dir = -1, switches = 0, first_dir = -1;

   always #5 clk = ~clk;

   ft245_sync_master #(
      .DATA_W    (DW),
      .RX_DEPTH  (RXD),
      .BURST_MAX (BM)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rxfn     (rxfn),
      .txen     (txen),
      .din      (din),
      .dout     (dout),
      .rdn      (rdn),
      .wrn      (wrn),
      .oen      (oen),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready)
   );

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic note_dir(int d);
      if (!track_runs) return;
      if (first_dir < 0) first_dir = d;
      if (d == run_dir) run_len++;
      else begin
         if (run_dir >= 0) switches++;
         run_dir = d;
         run_len = 1;
      end
      check("burst_run_len_ok", 64'(run_len <= BM), 1);
   endtask

   task automatic cycles(int n);
      repeat (n) @(posedge clk);
      #6;
   endtask

   // Chip side: samples strobes mid-cycle, updates its outputs 4ns after posedge.
   always begin : chip_model
      logic          rdx, wrx;
      logic [DW-1:0] ds;
      @(negedge clk);
      rdx = !rdn && !rxfn;
      wrx = !wrn && !txen;
      ds  = dout;
      @(posedge clk);
      #4;
      check("rd_wr_overlap", 64'(rdx && wrx), 0);
      if (rdx) begin
         if (host_q.size() > 0) rx_exp.push_back(host_q.pop_front());
         note_dir(0);
      end
      if (wrx) begin
         host_got++;
         if (tx_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected: chip got %0h, required nothing", ds);
         end else begin
            check("tx_data", ds, tx_exp.pop_front());
         end
         note_dir(1);
      end
      if (host_q.size() > 0 && int'($urandom_range(99)) >= rx_block_pct) begin
         rxfn = 1'b0;
         din  = host_q[0];
      end else begin
         rxfn = 1'b1;
         din  = $urandom;
      end
      case (txen_mode)
         0:       txen = 1'b0;
         1:       txen = (cyc % 3 == 2);
         2:       txen = ($urandom_range(3) == 0);
         default: txen = 1'b1;
      endcase
      cyc++;
   end

   always begin : tx_source
      logic hs;
      @(negedge clk);
      hs = tx_valid && tx_ready;
      @(posedge clk);
      #4;
      if (hs && tx_src.size() > 0) tx_exp.push_back(tx_src.pop_front());
      if (tx_src.size() > 0) begin
         tx_valid = 1'b1;
         tx_data  = tx_src[0];
      end else begin
         tx_valid = 1'b0;
         tx_data  = $urandom;
      end
   end

   always begin : rdy_driver
      @(posedge clk);
      #4;
      case (rdy_mode)
         0:       rx_ready = 1'b0;
         1:       rx_ready = 1'b1;
         default: rx_ready = 1'($urandom_range(1));
      endcase
   end

   always begin : rx_monitor
      @(negedge clk);
      if (rst_n && rx_valid && rx_ready) begin
         rx_cnt++;
         if (rx_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected: got %0h, required nothing", rx_data);
         end else begin
            check("rx_data", rx_data, rx_exp.pop_front());
         end
      end
   end

   always begin : strobe_monitor
      static logic prdn = 1'b1, poen = 1'b1;
      static int   ncyc = 0, oen_fall = -100, rdn_rise = -100;
      @(negedge clk);
      ncyc++;
      if (rst_n) begin
         if (!rdn) check("oen_low_while_rdn_low", oen, 0);
         if (poen && !oen) oen_fall = ncyc;
         if (prdn && !rdn) check("rdn_fall_after_oen", 64'(ncyc - oen_fall), 1);
         if (!prdn && rdn) rdn_rise = ncyc;
         if (!poen && oen) check("oen_rise_after_rdn", 64'(ncyc - rdn_rise), 1);
      end
      prdn = rdn;
      poen = oen;
   end

   task automatic drain(string name, int budget);
      int n = 0;
      while (n < budget && (host_q.size() != 0 || rx_exp.size() != 0 || tx_src.size() != 0 ||
                            tx_exp.size() != 0 || !rdn || !oen || !wrn)) begin
         cycles(1);
         n++;
      end
      check({name, "_done_in_budget"}, 64'(n < budget), 1);
   endtask

   task automatic wait_low(string name, bit wr);
      int n = 0;
      while (n < 200 && (wr ? wrn : rdn)) begin
         cycles(1);
         n++;
      end
      check({name, "_strobe_seen"}, 64'(n < 200), 1);
   endtask

   task automatic reset_pulse(string name);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check({name, "_rdn"}, rdn, 1);
      check({name, "_wrn"}, wrn, 1);
      check({name, "_oen"}, oen, 1);
      check({name, "_rx_valid"}, rx_valid, 0);
      cycles(1);
      host_q.delete();
      rx_exp.delete();
      tx_src.delete();
      tx_exp.delete();
      cycles(1);
      rst_n = 1'b1;
   endtask

   task automatic check_idle(string name);
      cycles(3);
      check({name, "_rdn_idle"}, rdn, 1);
      check({name, "_wrn_idle"}, wrn, 1);
      check({name, "_oen_idle"}, oen, 1);
      check({name, "_state_idle"}, dut.state_q, IDLE);
   endtask

   initial begin : watchdog
      #2_000_000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int base, sz;
      #1 rst_n = 1'b0;
      #2;
      check("rst_rdn", rdn, 1);
      check("rst_wrn", wrn, 1);
      check("rst_oen", oen, 1);
      check("rst_dout", dout, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_tx_ready", tx_ready, 0);
      cycles(2);
      rst_n = 1'b1;
      cycles(2);

      // 1: five words with a ready consumer
      rdy_mode = 1;
      base = rx_cnt;
      for (int i = 1; i <= 5; i++) host_q.push_back(DW'(i));
      drain("t1", 300);
      check("t1_rx_count", 64'(rx_cnt - base), 5);

      // 2: twenty words against a stalled consumer
      rdy_mode = 0;
      base = rx_cnt;
      for (int i = 1; i <= 20; i++) host_q.push_back(DW'(i));
      cycles(60);
      check("t2_fill_le_depth", 64'(rx_exp.size() <= RXD), 1);
      check("t2_fill_ge_min", 64'(rx_exp.size() >= RXD - RX_MARGIN), 1);
      check("t2_no_loss", 64'(rx_exp.size() + host_q.size()), 20);
      check("t2_rdn_high", rdn, 1);
      sz = rx_exp.size();
      cycles(20);
      check("t2_stall_holds", 64'(rx_exp.size()), 64'(sz));
      rdy_mode = 1;
      drain("t2", 600);
      check("t2_rx_count", 64'(rx_cnt - base), 20);

      // 3: ten tx words with txen high every third cycle
      txen_mode = 1;
      base = host_got;
      for (int i = 0; i < 10; i++) tx_src.push_back(DW'(32'hA0 + i));
      drain("t3", 600);
      check("t3_tx_count", 64'(host_got - base), 10);

      // 4: both directions pending continuously
      txen_mode  = 0;
      track_runs = 1'b1;
      first_dir  = -1;
      run_dir    = -1;
      switches   = 0;
      for (int i = 0; i < 24; i++) begin
         host_q.push_back($urandom);
         tx_src.push_back($urandom);
      end
      sz = 0;
      while (sz < 2000 && host_q.size() != 0 && tx_src.size() != 0) begin
         cycles(1);
         sz++;
      end
      track_runs = 1'b0;
      check("t4_both_busy_in_budget", 64'(sz < 2000), 1);
      check("t4_first_is_read", 64'(first_dir), 0);
      check("t4_alternates", 64'(switches >= 6), 1);
      drain("t4", 1000);

      // 5: reset in the middle of a read burst, then of a write burst
      rdy_mode  = 0;
      txen_mode = 3;
      for (int i = 0; i < 30; i++) host_q.push_back($urandom);
      wait_low("t5r", 1'b0);
      reset_pulse("t5r");
      rdy_mode = 1;
      base = rx_cnt;
      for (int i = 0; i < 3; i++) host_q.push_back(DW'(32'h51 + i));
      drain("t5r", 300);
      check("t5r_rx_count", 64'(rx_cnt - base), 3);

      txen_mode = 1;
      for (int i = 0; i < 20; i++) tx_src.push_back($urandom);
      wait_low("t5w", 1'b1);
      reset_pulse("t5w");
      txen_mode = 0;
      base = host_got;
      for (int i = 0; i < 3; i++) tx_src.push_back(DW'(32'h61 + i));
      drain("t5w", 300);
      check("t5w_tx_count", 64'(host_got - base), 3);

      // 6: single-word transfers
      base = rx_cnt;
      host_q.push_back(32'hCAFE_0001);
      drain("t6r", 200);
      check("t6r_rx_count", 64'(rx_cnt - base), 1);
      check_idle("t6r");
      base = host_got;
      tx_src.push_back(32'hBEEF_0002);
      drain("t6w", 200);
      check("t6w_tx_count", 64'(host_got - base), 1);
      check_idle("t6w");

      // 7: randomised mixed traffic
      rdy_mode     = 2;
      txen_mode    = 2;
      rx_block_pct = 30;
      base = rx_cnt;
      sz   = host_got;
      for (int i = 0; i < 60; i++) begin
         host_q.push_back($urandom);
         tx_src.push_back($urandom);
      end
      drain("t7", 5000);
      check("t7_rx_count", 64'(rx_cnt - base), 60);
      check("t7_tx_count", 64'(host_got - sz), 60);
      rx_block_pct = 0;
      txen_mode    = 3;
      rdy_mode     = 1;
      check_idle("t7");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
